// File: rtl/cpu_run_controller.sv
// Run/step/halt sequencer that owns the CPU core reset and clock enable.
// Boots the core, then runs or single-steps it on operator commands and counts retirements.
module cpu_run_controller #(
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 4'hF,
  parameter int unsigned RESET_HOLD = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    step,
  input  logic                    stop,
  input  logic                    bp_enable,
  input  logic [PC_WIDTH-1:0]     bp_addr,
  input  logic [OPCODE_WIDTH-1:0] cpu_opcode,
  input  logic [PC_WIDTH-1:0]     cpu_pc,
  input  logic                    cpu_instr_done,
  output logic                    cpu_reset,
  output logic                    cpu_en,
  output logic                    running,
  output logic                    halted,
  output logic [2:0]              state,
  output logic [CNT_WIDTH-1:0]    instr_count
);

  localparam int unsigned BootW = $clog2(RESET_HOLD + 1);
  localparam logic [BootW-1:0] BootLast = BootW'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    StBoot  = 3'd0,
    StPause = 3'd1,
    StRun   = 3'd2,
    StStep  = 3'd3,
    StHalt  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [BootW-1:0]     boot_q, boot_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 pend_q, pend_d;
  logic                 start_q, step_q;
  logic                 start_rise, step_rise, is_halt;

  assign start_rise = start & ~start_q;
  assign step_rise  = step & ~step_q;
  assign is_halt    = (cpu_opcode == HALT_OPCODE);
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    boot_d  = boot_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      StBoot: begin
        boot_d = boot_q + BootW'(1);
        if (boot_q == BootLast) state_d = StPause;
      end
      StPause: begin
        if (start_rise) begin
          state_d = StRun;
          pend_d  = 1'b0;
        end else if (step_rise) begin
          state_d = StStep;
          pend_d  = 1'b0;
        end
      end
      StRun: begin
        if (stop) pend_d = 1'b1;
        // Only an instruction boundary can take us out of RUN.
        if (cpu_instr_done) begin
          cnt_d = cnt_inc;
          if (is_halt)                                state_d = StHalt;
          else if (pend_q || stop)                    state_d = StPause;
          else if (bp_enable && (cpu_pc == bp_addr))  state_d = StPause;
        end
      end
      StStep: begin
        if (cpu_instr_done) begin
          cnt_d   = cnt_inc;
          state_d = is_halt ? StHalt : StPause;
        end
      end
      StHalt: begin
        if (start_rise) begin
          state_d = StBoot;
          boot_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StBoot;
      boot_q    <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      start_q   <= 1'b0;
      step_q    <= 1'b0;
      cpu_reset <= 1'b1;
      cpu_en    <= 1'b0;
      running   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state_q   <= state_d;
      boot_q    <= boot_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      start_q   <= start;
      step_q    <= step;
      cpu_reset <= (state_d == StBoot);
      cpu_en    <= (state_d == StRun) || (state_d == StStep);
      running   <= (state_d == StRun) || (state_d == StStep);
      halted    <= (state_d == StHalt);
    end
  end

  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule
